// File: rtl/round_key_store.sv
// Round-key schedule store: accepts expanded key words, streams them byte-serially.
// Define KEY_STORE_PARITY_EN to add per-byte even parity with a sticky error flag.
module round_key_store #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_start,
    input  logic        wr_en,
    input  logic [31:0] wr_word,
    output logic        keys_ready,
    input  logic        rd_start,
    input  logic        rd_dir,
    input  logic        rd_round,
    output logic [7:0]  key_byte,
    output logic        key_valid,
    output logic        round_done,
    output logic        last_round,
    output logic [3:0]  cur_round,
    output logic        busy,
    output logic        parity_err
);

    localparam int DEPTH = 4 * (NUM_ROUNDS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [3:0]    LAST_INDEX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    state_t         state;
    logic           dir;
    logic [3:0]     cnt;
    logic [PW-1:0]  wr_ptr;
    logic           wr_fire;
    logic [AW-1:0]  wr_addr;
    logic [31:0]    mem [DEPTH];

    logic           final_rnd;
    logic [3:0]     next_round;
    logic [3:0]     sel_round;
    logic [3:0]     sel_cnt;
    logic [AW-1:0]  rd_addr;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic           load;

    // A wr_start restarts the schedule even when the previous one is complete.
    assign wr_fire = wr_en && (wr_start || !keys_ready);
    assign wr_addr = wr_start ? '0 : wr_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            keys_ready <= 1'b0;
        end else if (wr_start) begin
            wr_ptr     <= wr_en ? PW'(1) : '0;
            keys_ready <= 1'b0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_ptr == LAST_PTR) begin
                keys_ready <= 1'b1;
            end
        end
    end

    assign final_rnd  = dir ? (cur_round == 4'd0) : (cur_round == LAST_INDEX);
    assign next_round = dir ? cur_round - 4'd1 : cur_round + 4'd1;

    // Address of the byte that will be on key_byte after the next edge.
    always_comb begin
        sel_round = cur_round;
        sel_cnt   = cnt + 4'd1;
        if (state != STREAM) begin
            sel_cnt = 4'd0;
        end else if (cnt == 4'd15) begin
            sel_round = next_round;
            sel_cnt   = 4'd0;
        end
    end

    assign rd_addr = AW'({sel_round, sel_cnt[3:2]});
    assign rd_word = mem[rd_addr];

    always_comb begin
        rd_byte = rd_word[31:24];
        unique case (sel_cnt[1:0])
            2'd0: rd_byte = rd_word[31:24];
            2'd1: rd_byte = rd_word[23:16];
            2'd2: rd_byte = rd_word[15:8];
            2'd3: rd_byte = rd_word[7:0];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign load = !wr_start &&
                  ((state == WAIT && rd_round) ||
                   (state == STREAM &&
                    (cnt != 4'd15 || (!final_rnd && rd_round))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_byte <= 8'h00;
        end else if (load) begin
            key_byte <= rd_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= 1'b0;
            cnt        <= 4'd0;
            cur_round  <= 4'd0;
            busy       <= 1'b0;
            key_valid  <= 1'b0;
            round_done <= 1'b0;
            last_round <= 1'b0;
        end else if (wr_start) begin
            state      <= IDLE;
            busy       <= 1'b0;
            key_valid  <= 1'b0;
            round_done <= 1'b0;
            last_round <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_start && keys_ready) begin
                        dir       <= rd_dir;
                        cur_round <= rd_dir ? LAST_INDEX : 4'd0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_round) begin
                        state     <= STREAM;
                        key_valid <= 1'b1;
                        cnt       <= 4'd0;
                    end
                end
                STREAM: begin
                    if (cnt == 4'd15) begin
                        round_done <= 1'b0;
                        last_round <= 1'b0;
                        if (final_rnd) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            key_valid <= 1'b0;
                        end else begin
                            cur_round <= next_round;
                            cnt       <= 4'd0;
                            if (!rd_round) begin
                                state     <= WAIT;
                                key_valid <= 1'b0;
                            end
                        end
                    end else begin
                        cnt        <= cnt + 4'd1;
                        round_done <= (cnt == 4'd14);
                        last_round <= (cnt == 4'd14) && final_rnd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_STORE_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic [3:0] rd_par_word;
    logic       rd_par;
    logic       key_par;
    logic       par_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            par_mem[wr_addr] <= {^wr_word[31:24], ^wr_word[23:16],
                                 ^wr_word[15:8], ^wr_word[7:0]};
        end
    end

    assign rd_par_word = par_mem[rd_addr];
    assign rd_par      = rd_par_word[3 - sel_cnt[1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_par <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            if (load) begin
                key_par <= rd_par;
            end
            if (wr_start) begin
                par_q <= 1'b0;
            end else if (key_valid && ((^key_byte) != key_par)) begin
                par_q <= 1'b1;
            end
        end
    end

    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
